// File: rtl/spongent_ctrl_pkg.sv
// spongent_ctrl_pkg
// Shared definitions for the SPONGENT hash sequencer: the controller state
// encoding, the padding-block constant and the digest block-count helper.
// Optional watchdog macro used by the controller: SPONGENT_CTRL_WATCHDOG_EN.
package spongent_ctrl_pkg;

    typedef enum logic [3:0] {
        StAccept,
        StAbsStart,
        StAbsWait,
        StPadStart,
        StPadWait,
        StSqOut,
        StSqStart,
        StSqWait,
        StCoreRst
    } ctrl_state_e;

    // Widest RATE the pad helper can produce; callers slice the low RATE bits.
    localparam int unsigned MaxRate = 64;

    // Padding block: a single 1 in the MSB of the RATE-bit block, rest zero.
    function automatic logic [MaxRate-1:0] pad_block(input int unsigned rate);
        logic [MaxRate-1:0] blk;
        blk = '0;
        blk[rate-1] = 1'b1;
        return blk;
    endfunction

    function automatic int unsigned digest_blocks(input int unsigned digest_size,
                                                  input int unsigned rate);
        return digest_size / rate;
    endfunction

    function automatic logic is_wait_state(input ctrl_state_e s);
        return (s == StAbsWait) || (s == StPadWait) || (s == StSqWait);
    endfunction

    function automatic logic is_start_state(input ctrl_state_e s);
        return (s == StAbsStart) || (s == StPadStart) || (s == StSqStart);
    endfunction

endpackage

// File: rtl/spongent_ctrl_watchdog.sv
// spongent_ctrl_watchdog
// Per-permutation timeout counter. Counts consecutive cycles spent in a WAIT
// state and flags expiry on the TIMEOUT_CYCLES-th such cycle. Any cycle with
// run_i low (START, OUT, ACCEPT, reset states) clears the count.
// Only instantiated when SPONGENT_CTRL_WATCHDOG_EN is defined.
// Ports:
//   clk       - clock
//   reset     - synchronous active-high reset
//   run_i     - controller is in a WAIT state this cycle
//   expired_o - this is the TIMEOUT_CYCLES-th consecutive WAIT cycle
module spongent_ctrl_watchdog
    import spongent_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || !run_i) begin
            cnt_q <= '0;
        end else if (!expired_o) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expired_o = run_i && (cnt_q == LastCnt);

endmodule

// File: rtl/spongent_hash_ctrl.sv
// spongent_hash_ctrl
// Sequencer that drives a spongent_parallel core to hash a valid/ready message
// stream: absorbs each RATE-bit block, absorbs one padding block, then squeezes
// DIGEST_SIZE/RATE output blocks onto a valid/ready digest stream. The
// controller owns the core reset (pulsed after every hash and on abort).
// Optional feature: define SPONGENT_CTRL_WATCHDOG_EN to time out each core
// permutation after TIMEOUT_CYCLES wait cycles (sets sticky error_o).
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   abort_i                      - soft abort back to the idle state
//   msg_valid_i/msg_ready_o      - message block handshake
//   msg_data_i, msg_last_i       - message block and final-block flag
//   dig_valid_o/dig_ready_i      - digest block handshake
//   dig_data_o, dig_last_o       - digest block and final-block flag
//   busy_o, error_o              - hash in progress, sticky watchdog error
//   core_reset_o                 - core reset (high in reset and CORE_RST)
//   core_start_continue_o        - core start pulse
//   core_msg_data_available_o    - core absorbs core_data_in_o on this start
//   core_data_in_o               - block presented to the core
//   core_busy_i, core_data_out_i - core status and rate output
module spongent_hash_ctrl
    import spongent_ctrl_pkg::*;
#(
    parameter int unsigned RATE           = 8,
    parameter int unsigned DIGEST_SIZE    = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            abort_i,
    input  logic            msg_valid_i,
    output logic            msg_ready_o,
    input  logic [RATE-1:0] msg_data_i,
    input  logic            msg_last_i,
    output logic            dig_valid_o,
    input  logic            dig_ready_i,
    output logic [RATE-1:0] dig_data_o,
    output logic            dig_last_o,
    output logic            busy_o,
    output logic            error_o,
    output logic            core_reset_o,
    output logic            core_start_continue_o,
    output logic            core_msg_data_available_o,
    output logic [RATE-1:0] core_data_in_o,
    input  logic            core_busy_i,
    input  logic [RATE-1:0] core_data_out_i
);

    localparam int unsigned DigestBlocks = digest_blocks(DIGEST_SIZE, RATE);
    localparam int unsigned CntW = (DigestBlocks > 1) ? $clog2(DigestBlocks) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DigestBlocks - 1);
    localparam logic [MaxRate-1:0] PadWord = pad_block(RATE);
    localparam logic [RATE-1:0] PadBlock = PadWord[RATE-1:0];

    ctrl_state_e     state_q;
    logic [RATE-1:0] data_in_q;
    logic            last_q;
    logic            seen_busy_q;
    logic            rst_pulse_q;
    logic [CntW-1:0] cnt_q;
    logic            error_q;

    logic in_wait;
    logic wait_done;
    logic wd_expired;
    logic msg_hs;
    logic dig_hs;

    assign in_wait = is_wait_state(state_q);
    // The core may raise busy a cycle after the start pulse, so a WAIT only
    // ends once busy has been observed high and has dropped again.
    assign wait_done = seen_busy_q && !core_busy_i;

`ifdef SPONGENT_CTRL_WATCHDOG_EN
    spongent_ctrl_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .run_i    (in_wait),
        .expired_o(wd_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign wd_expired     = 1'b0;
`endif

    // Handshake outputs are gated by abort so nothing completes in that cycle.
    assign msg_ready_o = (state_q == StAccept) && !reset && !abort_i;
    assign dig_valid_o = (state_q == StSqOut) && !abort_i;
    assign dig_data_o  = (state_q == StSqOut) ? core_data_out_i : '0;
    assign dig_last_o  = (state_q == StSqOut) && (cnt_q == LastCnt);
    assign busy_o      = (state_q != StAccept);
    assign error_o     = error_q;

    assign core_reset_o              = reset | rst_pulse_q;
    assign core_start_continue_o     = is_start_state(state_q);
    assign core_msg_data_available_o = (state_q == StAbsStart) || (state_q == StPadStart);
    assign core_data_in_o            = data_in_q;

    assign msg_hs = msg_valid_i && msg_ready_o;
    assign dig_hs = dig_valid_o && dig_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StAccept;
            data_in_q   <= '0;
            last_q      <= 1'b0;
            seen_busy_q <= 1'b0;
            rst_pulse_q <= 1'b0;
            cnt_q       <= '0;
            error_q     <= 1'b0;
        end else begin
            rst_pulse_q <= 1'b0;
            if (in_wait && core_busy_i) begin
                seen_busy_q <= 1'b1;
            end

            case (state_q)
                StAccept: begin
                    if (msg_hs) begin
                        data_in_q <= msg_data_i;
                        last_q    <= msg_last_i;
                        state_q   <= StAbsStart;
                    end
                end
                StAbsStart: begin
                    seen_busy_q <= 1'b0;
                    state_q     <= StAbsWait;
                end
                StAbsWait: begin
                    if (wait_done) begin
                        if (last_q) begin
                            data_in_q <= PadBlock;
                            state_q   <= StPadStart;
                        end else begin
                            state_q <= StAccept;
                        end
                    end
                end
                StPadStart: begin
                    seen_busy_q <= 1'b0;
                    state_q     <= StPadWait;
                end
                StPadWait: begin
                    if (wait_done) begin
                        cnt_q   <= '0;
                        state_q <= StSqOut;
                    end
                end
                StSqOut: begin
                    if (dig_hs) begin
                        if (dig_last_o) begin
                            rst_pulse_q <= 1'b1;
                            state_q     <= StCoreRst;
                        end else begin
                            cnt_q   <= cnt_q + CntW'(1);
                            state_q <= StSqStart;
                        end
                    end
                end
                StSqStart: begin
                    seen_busy_q <= 1'b0;
                    state_q     <= StSqWait;
                end
                StSqWait: begin
                    if (wait_done) begin
                        state_q <= StSqOut;
                    end
                end
                StCoreRst: begin
                    cnt_q     <= '0;
                    data_in_q <= '0;
                    state_q   <= StAccept;
                end
                default: begin
                    rst_pulse_q <= 1'b1;
                    state_q     <= StCoreRst;
                end
            endcase

            // Later assignments win: watchdog expiry, then abort, override the FSM.
            if (wd_expired) begin
                error_q     <= 1'b1;
                rst_pulse_q <= 1'b1;
                state_q     <= StCoreRst;
            end
            if (abort_i) begin
                rst_pulse_q <= 1'b1;
                state_q     <= StCoreRst;
            end
        end
    end

endmodule

// File: tb/tb_spongent_hash_ctrl.sv
// tb_spongent_hash_ctrl
// Self-checking bench for spongent_hash_ctrl. A behavioural core (SPONGENT
// permutation with randomised busy latency) stands in for spongent_parallel;
// digests are compared against a whole-message reference hash.
module tb_spongent_hash_ctrl;

    localparam int unsigned Rate         = 8;
    localparam int unsigned DigestSize   = 128;
    localparam int unsigned Timeout      = 16;
    localparam int unsigned DigestBlocks = DigestSize / Rate;
    localparam int          Budget       = 3000;

    logic       clk = 1'b0;
    logic       reset, abort;
    logic       msg_valid, msg_ready, msg_last;
    logic [7:0] msg_data;
    logic       dig_valid, dig_ready, dig_last;
    logic [7:0] dig_data;
    logic       busy, error;
    logic       core_reset, core_start, core_mda, core_busy;
    logic [7:0] core_data_in, core_data_out;

    logic ready_mode, ready_force, ready_rnd;
    logic stuck;
    assign dig_ready = ready_mode ? ready_force : ready_rnd;

    always #5 clk = ~clk;

    spongent_hash_ctrl #(
        .RATE          (Rate),
        .DIGEST_SIZE   (DigestSize),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .abort_i                  (abort),
        .msg_valid_i              (msg_valid),
        .msg_ready_o              (msg_ready),
        .msg_data_i               (msg_data),
        .msg_last_i               (msg_last),
        .dig_valid_o              (dig_valid),
        .dig_ready_i              (dig_ready),
        .dig_data_o               (dig_data),
        .dig_last_o               (dig_last),
        .busy_o                   (busy),
        .error_o                  (error),
        .core_reset_o             (core_reset),
        .core_start_continue_o    (core_start),
        .core_msg_data_available_o(core_mda),
        .core_data_in_o           (core_data_in),
        .core_busy_i              (core_busy),
        .core_data_out_i          (core_data_out)
    );

    // ---------------- SPONGENT-128/128/8 permutation (b = 136) ----------------
    function automatic logic [135:0] spongent_perm(input logic [135:0] s_in);
        logic [63:0]  sbox;
        logic [135:0] s, t;
        logic [6:0]   lc, rev;
        sbox = 64'h63C958A7F4120BDE;
        s    = s_in;
        lc   = 7'h7A;
        for (int r = 0; r < 70; r++) begin
            s[6:0] = s[6:0] ^ lc;
            for (int i = 0; i < 7; i++) rev[i] = lc[6-i];
            s[135:129] = s[135:129] ^ rev;
            for (int n = 0; n < 34; n++) s[4*n +: 4] = sbox[4*s[4*n +: 4] +: 4];
            for (int j = 0; j < 135; j++) t[(j*34) % 135] = s[j];
            t[135] = s[135];
            s  = t;
            lc = {lc[5:0], lc[6] ^ lc[5]};
        end
        return s;
    endfunction

    // Whole-message reference: absorb blocks, absorb pad, squeeze 16 bytes.
    function automatic logic [127:0] ref_hash(input int n, input logic [31:0] blks);
        logic [135:0] s;
        logic [127:0] d;
        s = '0;
        d = '0;
        for (int i = 0; i < n; i++) begin
            s[7:0] = s[7:0] ^ blks[8*i +: 8];
            s = spongent_perm(s);
        end
        s[7:0] = s[7:0] ^ 8'h80;
        s = spongent_perm(s);
        for (int i = 0; i < 16; i++) begin
            d = {d[119:0], s[7:0]};
            if (i < 15) s = spongent_perm(s);
        end
        return d;
    endfunction

    // ---------------- behavioural core ----------------
    logic [135:0] cst;
    logic [7:0]   cdout;
    logic         cbusy;
    int           phase, run_left;
    assign core_busy     = cbusy | stuck;
    assign core_data_out = cdout;

    always @(posedge clk) begin
        if (core_reset) begin
            cst <= '0; cdout <= '0; cbusy <= 1'b0; phase <= 0; run_left <= 0;
        end else begin
            case (phase)
                0: if (core_start) begin
                    cst <= spongent_perm(core_mda ? (cst ^ {128'b0, core_data_in}) : cst);
                    run_left <= int'($urandom_range(1, 5));
                    if ($urandom_range(0, 1) == 1) begin
                        cbusy <= 1'b1; phase <= 2;
                    end else begin
                        phase <= 1;
                    end
                end
                1: begin cbusy <= 1'b1; phase <= 2; end
                default: begin
                    if (run_left == 0) begin
                        cbusy <= 1'b0; cdout <= cst[7:0]; phase <= 0;
                    end else begin
                        run_left <= run_left - 1;
                    end
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] abs_q[$];
    logic [8:0] dig_q[$];
    int         sq_starts, viol_ready;

    initial forever begin
        @(negedge clk);
        if (core_start) begin
            if (core_mda) abs_q.push_back(core_data_in);
            else sq_starts++;
        end
        if (dig_valid && dig_ready) dig_q.push_back({dig_last, dig_data});
        if (core_busy && msg_ready) viol_ready++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        ready_rnd = 1'($urandom_range(0, 1));
    end

    // ---------------- checking ----------------
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic clear_mon();
        abs_q.delete();
        dig_q.delete();
        sq_starts  = 0;
        viol_ready = 0;
    endtask

    task automatic send_msg(input int n, input logic [31:0] blks);
        int w;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            msg_valid = 1'b1;
            msg_data  = blks[8*i +: 8];
            msg_last  = (i == n - 1);
            w = 0;
            @(negedge clk);
            while (!msg_ready && w < Budget) begin
                w++;
                @(negedge clk);
            end
            if (!msg_ready) begin
                note_timeout("msg_accept");
                msg_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while ((dig_q.size() < DigestBlocks || busy) && w < Budget) begin
            @(negedge clk);
            w++;
        end
        #1;
        if (w >= Budget) note_timeout(tag);
    endtask

    task automatic check_hash(input string tag, input int n, input logic [31:0] blks,
                              input logic [127:0] exp, output logic [127:0] got);
        logic [47:0] act_abs, exp_abs;
        logic [15:0] lmask;
        got = '0; lmask = '0; act_abs = '0; exp_abs = '0;
        foreach (dig_q[i]) begin
            got = {got[119:0], dig_q[i][7:0]};
            if (dig_q[i][8] && i < 16) lmask[i] = 1'b1;
        end
        foreach (abs_q[i]) act_abs = {act_abs[39:0], abs_q[i]};
        for (int i = 0; i < n; i++) exp_abs = {exp_abs[39:0], blks[8*i +: 8]};
        exp_abs = {exp_abs[39:0], 8'h80};
        check({tag, " digest"}, got, exp);
        check({tag, " absorb_starts"}, abs_q.size(), n + 1);
        check({tag, " absorb_data"}, act_abs, exp_abs);
        check({tag, " squeeze_starts"}, sq_starts, DigestBlocks - 1);
        check({tag, " dig_last_pos"}, lmask, 16'h8000);
        check({tag, " ready_in_wait"}, viol_ready, 0);
        check({tag, " idle_after"}, {msg_ready, busy}, 2'b10);
    endtask

    task automatic run_hash(input string tag, input int n, input logic [31:0] blks,
                            input logic [127:0] exp, output logic [127:0] got);
        clear_mon();
        send_msg(n, blks);
        wait_idle(tag);
        check_hash(tag, n, blks, exp, got);
    endtask

    typedef struct {
        int           n;
        logic [31:0]  blks;
        logic [127:0] exp;
    } vec_t;

    vec_t         tbl[4];
    logic [127:0] got, got2;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1; abort = 1'b0; msg_valid = 1'b0; msg_last = 1'b0; msg_data = '0;
        ready_mode = 1'b0; ready_force = 1'b0; stuck = 1'b0;
        sq_starts = 0; viol_ready = 0;

        tbl[0].n = 1; tbl[0].blks = 32'h00000041;
        tbl[1].n = 3; tbl[1].blks = 32'h00636261;
        tbl[2].n = 2; tbl[2].blks = 32'h0000ff00;
        tbl[3].n = 4; tbl[3].blks = 32'hefbeadde;
        foreach (tbl[i]) tbl[i].exp = ref_hash(tbl[i].n, tbl[i].blks);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {core_reset, msg_ready, busy, dig_valid, dig_last, core_start, core_mda, error,
               core_data_in, dig_data},
              {8'b1000_0000, 16'h0000});
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("after_reset", {core_reset, msg_ready, busy}, 3'b010);

        // table-driven messages with a randomly stalling consumer
        for (int i = 0; i < 4; i++) begin
            run_hash($sformatf("tbl%0d", i), tbl[i].n, tbl[i].blks, tbl[i].exp, got);
        end

        // random messages
        for (int i = 0; i < 4; i++) begin
            int          n;
            logic [31:0] b;
            n = int'($urandom_range(1, 4));
            b = $urandom;
            run_hash($sformatf("rnd%0d", i), n, b, ref_hash(n, b), got);
        end

        // consumer stall of 5 cycles on the third digest block
        begin
            int         bad, w;
            logic [7:0] d0;
            bad = 0;
            clear_mon();
            ready_mode = 1'b1; ready_force = 1'b0;
            send_msg(tbl[0].n, tbl[0].blks);
            for (int k = 0; k < DigestBlocks; k++) begin
                w = 0;
                @(negedge clk);
                while (!dig_valid && w < Budget) begin
                    w++;
                    @(negedge clk);
                end
                if (!dig_valid) begin
                    note_timeout("stall_dig_valid");
                    break;
                end
                if (k == 2) begin
                    d0 = dig_data;
                    repeat (5) begin
                        @(posedge clk);
                        #1;
                        @(negedge clk);
                        #1;
                        if (!dig_valid || dig_data !== d0 || sq_starts != 2) bad++;
                    end
                end
                @(posedge clk);
                #1 ready_force = 1'b1;
                @(negedge clk);
                @(posedge clk);
                #1 ready_force = 1'b0;
            end
            check("stall_hold", bad, 0);
            ready_mode = 1'b0;
            wait_idle("stall_idle");
            check_hash("stall", tbl[0].n, tbl[0].blks, tbl[0].exp, got);
        end

        // abort while idle: no handshake, one CORE_RST cycle
        clear_mon();
        @(posedge clk);
        #1;
        msg_valid = 1'b1; msg_data = 8'h55; msg_last = 1'b1; abort = 1'b1;
        @(negedge clk);
        check("abort_idle_ready_gated", msg_ready, 1'b0);
        @(posedge clk);
        #1 abort = 1'b0; msg_valid = 1'b0; msg_last = 1'b0;
        @(negedge clk);
        check("abort_idle_core_reset", core_reset, 1'b1);
        @(negedge clk);
        check("abort_idle_back", {core_reset, msg_ready, busy}, 3'b010);
        check("abort_idle_no_absorb", abs_q.size(), 0);

        // abort during the second block's absorb wait
        begin
            int w;
            clear_mon();
            send_msg(2, 32'h00006261);
            w = 0;
            @(negedge clk);
            while (!core_busy && w < Budget) begin
                w++;
                @(negedge clk);
            end
            if (!core_busy) note_timeout("abort_wait_busy");
            abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            @(negedge clk);
            check("abort_core_rst", {core_reset, busy}, 2'b11);
            @(negedge clk);
            check("abort_recovered", {core_reset, msg_ready, busy}, 3'b010);
            repeat (10) @(negedge clk);
            check("abort_no_digest", dig_q.size(), 0);
            check("abort_absorbed", abs_q.size(), 2);
        end

        // same message twice back-to-back after the abort
        run_hash("b2b_a", 2, 32'h00006261, ref_hash(2, 32'h00006261), got);
        run_hash("b2b_b", 2, 32'h00006261, ref_hash(2, 32'h00006261), got2);
        check("b2b_equal", got2, got);
        check("no_error", error, 1'b0);

`ifdef SPONGENT_CTRL_WATCHDOG_EN
        begin
            int cyc;
            clear_mon();
            stuck = 1'b1;
            send_msg(1, 32'h00000041);
            cyc = 0;
            @(negedge clk);
            while (!error && cyc < Budget) begin
                cyc++;
                @(negedge clk);
            end
            // one ABS_START cycle followed by Timeout wait cycles
            check("wd_cycles", cyc, Timeout + 1);
            check("wd_core_rst", {core_reset, error}, 2'b11);
            @(negedge clk);
            check("wd_idle", {msg_ready, busy, error}, 3'b101);
            stuck = 1'b0;
            repeat (10) @(negedge clk);
            check("wd_sticky", error, 1'b1);
            check("wd_no_digest", dig_q.size(), 0);
            @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check("wd_cleared", error, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
